// File: rtl/counter_interval_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// counter_interval_arbiter_pkg: shared state encoding and interval width
// Rev 1.0
// ============================================================================
package counter_interval_arbiter_pkg;

  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_interval_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2: combinational two-way round-robin picker
// Rev 1.0
// ============================================================================
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       any
);

  // On a tie the requester that was not served last wins.
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
  assign any    = |req;

endmodule
`default_nettype wire

// File: rtl/counter_interval_arbiter.sv
`default_nettype none
// ============================================================================
// counter_interval_arbiter: shares one external 0..15 counter between two
// interval requesters with round-robin grant, completion pulse and abort.
// Rev 1.0
// ============================================================================
module counter_interval_arbiter
  import counter_interval_arbiter_pkg::*;
#(
  parameter logic IDLE_CLR = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             TICK,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [LEN_W-1:0] LEN0,
  input  logic [LEN_W-1:0] LEN1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             BUSY,
  output logic             CNT_CE,
  output logic             CNT_CLR,
  input  logic [LEN_W-1:0] CNT_Q
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             r_last;
  logic             w_last_nxt;

  logic [1:0]       w_pick;
  logic             w_any;
  logic             w_match;
  logic             w_req_held;

  rr_pick2 u_pick (
    .req  ({REQ1, REQ0}),
    .last (r_last),
    .gnt  (w_pick),
    .any  (w_any)
  );

  assign w_match    = (CNT_Q == r_len);
  assign w_req_held = |({REQ1, REQ0} & r_gnt);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_len_nxt   = r_len;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_CLEAR;
          w_gnt_nxt   = w_pick;
          w_len_nxt   = w_pick[1] ? LEN1 : LEN0;
        end
      end
      ST_CLEAR, ST_RUN: begin
        // Withdrawal wins over a simultaneous match: no DONE for an aborted interval.
        if (!w_req_held) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
          w_last_nxt  = r_gnt[1];
        end else if (r_state == ST_CLEAR) begin
          w_state_nxt = ST_RUN;
        end else if (w_match) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
        w_last_nxt  = r_gnt[1];
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_len   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_len   <= w_len_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign GNT0    = r_gnt[0];
  assign GNT1    = r_gnt[1];
  assign DONE0   = (r_state == ST_DONE) & r_gnt[0];
  assign DONE1   = (r_state == ST_DONE) & r_gnt[1];
  assign BUSY    = (r_state != ST_IDLE);
  // Stop enabling once the target is reached so the counter never wraps.
  assign CNT_CE  = (r_state == ST_RUN) & TICK & ~w_match;
  assign CNT_CLR = (r_state == ST_CLEAR) | (IDLE_CLR & (r_state == ST_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_counter_interval_arbiter.sv
`default_nettype none
// ============================================================================
// tb_counter_interval_arbiter: directed bench with an attached 0..15 counter
// Rev 1.0
// ============================================================================
module tb_counter_interval_arbiter;

  logic       C = 1'b0;
  logic       CLR, TICK, REQ0, REQ1;
  logic [3:0] LEN0, LEN1;
  logic       GNT0, GNT1, DONE0, DONE1, BUSY, CNT_CE, CNT_CLR;
  logic [3:0] cnt_q;

  int n_tests = 0;
  int n_fail  = 0;
  int ce_cnt;
  int done_at;
  logic [4:0] exp2 [25];

  always #5 C = ~C;

  // External counter with asynchronous clear.
  always @(posedge C or posedge CNT_CLR) begin
    if (CNT_CLR)     cnt_q <= 4'd0;
    else if (CNT_CE) cnt_q <= cnt_q + 4'd1;
  end

  counter_interval_arbiter #(.IDLE_CLR(1'b1)) dut (
    .C       (C),
    .CLR     (CLR),
    .TICK    (TICK),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .LEN0    (LEN0),
    .LEN1    (LEN1),
    .GNT0    (GNT0),
    .GNT1    (GNT1),
    .DONE0   (DONE0),
    .DONE1   (DONE1),
    .BUSY    (BUSY),
    .CNT_CE  (CNT_CE),
    .CNT_CLR (CNT_CLR),
    .CNT_Q   (cnt_q)
  );

  function automatic logic [4:0] outs();
    return {BUSY, DONE1, DONE0, GNT1, GNT0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge C);
    #2;
  endtask

  initial begin
    CLR = 1'b1; TICK = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; LEN0 = 4'd0; LEN1 = 4'd0;
    repeat (2) cyc();
    check("rst_outs", outs(), 5'b00000);
    check("rst_ce", CNT_CE, 1'b0);
    check("rst_cnt_clr", CNT_CLR, 1'b1);

    // Single request, LEN0 = 5, TICK always high
    CLR = 1'b0; REQ0 = 1'b1; LEN0 = 4'd5; TICK = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      check("t1_q", cnt_q, (c <= 2) ? 0 : ((c - 2 > 5) ? 5 : c - 2));
      check("t1_outs", outs(), (c == 8) ? 5'b10101 : 5'b10001);
      check("t1_ce", CNT_CE, (c >= 2 && c <= 6));
    end
    REQ0 = 1'b0;
    cyc();
    check("t1_idle_outs", outs(), 5'b00000);
    check("t1_idle_q", cnt_q, 4'd0);

    // Contention from a fresh reset: grants 0,1,0,1 with a 1-cycle IDLE gap
    CLR = 1'b1;
    cyc();
    CLR = 1'b0; LEN0 = 4'd2; LEN1 = 4'd3; REQ0 = 1'b1; REQ1 = 1'b1;
    exp2 = '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10101,
             5'b00000,
             5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b11010,
             5'b00000,
             5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10101,
             5'b00000,
             5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b11010};
    for (int c = 1; c <= 25; c++) begin
      cyc();
      check($sformatf("t2_outs_c%0d", c), outs(), exp2[c-1]);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    cyc();
    check("t2_idle_outs", outs(), 5'b00000);

    // Zero length on requester 1
    LEN1 = 4'd0; REQ1 = 1'b1; TICK = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      check("t3_zero_ce", CNT_CE, 1'b0);
      check("t3_zero_done1", DONE1, (c == 3));
    end
    REQ1 = 1'b0;
    cyc();
    check("t3_zero_idle", outs(), 5'b00000);

    // Sparse ticks: LEN0 = 3, TICK every 4th cycle
    LEN0 = 4'd3; REQ0 = 1'b1; TICK = 1'b0; ce_cnt = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (DONE0 && done_at == 0) done_at = c;
      if (DONE0) REQ0 = 1'b0;
      TICK = ((c % 4) == 0);
      #1;
      if (CNT_CE) ce_cnt++;
    end
    check("t3_sparse_done_cycle", done_at, 14);
    check("t3_sparse_ce_pulses", ce_cnt, 3);

    // Abort REQ0 at CNT_Q = 6, pending REQ1 granted right after
    LEN0 = 4'd15; LEN1 = 4'd12; REQ0 = 1'b1; TICK = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      check("t4_no_done0", DONE0, 1'b0);
      if (c == 1) begin
        check("t4_grant0", outs(), 5'b10001);
        REQ1 = 1'b1;
      end
    end
    check("t4_q_at_abort", cnt_q, 4'd6);
    REQ0 = 1'b0;
    cyc();
    check("t4_abort_idle", outs(), 5'b00000);
    cyc();
    check("t4_grant1", outs(), 5'b10010);

    // Reset mid-RUN at CNT_Q = 9, then a tie must go to REQ0
    for (int c = 11; c <= 20; c++) cyc();
    check("t5_q_before_reset", cnt_q, 4'd9);
    CLR = 1'b1; REQ0 = 1'b1;
    cyc();
    check("t5_rst_outs", outs(), 5'b00000);
    check("t5_rst_ce", CNT_CE, 1'b0);
    check("t5_rst_cnt_clr", CNT_CLR, 1'b1);
    check("t5_rst_q", cnt_q, 4'd0);
    CLR = 1'b0;
    cyc();
    check("t5_tie_after_reset", outs(), 5'b10001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
